// File: rtl/sample_rx_pkg.sv
// sample_rx_pkg: shared state encoding, default sample width and count width helper
package sample_rx_pkg;
  localparam int DATA_W_DEF = 16;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int CNT_W = cnt_width(DATA_W_DEF);
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 FIFO with combinational head read and async reset to empty
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic w_wr, w_rd;
  assign w_rd  = pop && !empty;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_wr  = push && (!full || w_rd);
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout  = r_mem[r_rp];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      count <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      count <= count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/sample_rx.sv
// sample_rx: framed serial-to-parallel receiver feeding the FIR filter through a small FIFO
module sample_rx
  import sample_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          bit_en,
  input  logic                          sdata,
  input  logic                          fsync,
  input  logic                          ready,
  input  logic                          err_clr,
  output logic [DATA_W-1:0]             dataout,
  output logic                          dout_enable,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  output logic                          frame_err
);
  localparam int CW = cnt_width(DATA_W);
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [DATA_W-1:0] r_shift, w_shift_nx, w_head;
  logic w_new, w_cap, w_done, w_full, w_empty, w_pop, w_ovf_set, w_ferr_set;
  always_comb begin
    w_new      = bit_en && fsync;
    w_cap      = bit_en && (fsync || r_state == ST_SHIFT);
    w_shift_nx = w_new ? DATA_W'(sdata) : {r_shift[DATA_W-2:0], sdata};
    w_cnt_nx   = w_new ? CW'(1) : r_cnt + CW'(1);
    w_done     = w_cap && w_cnt_nx == CW'(DATA_W);
    w_state_nx = w_done ? ST_IDLE : w_cap ? ST_SHIFT : r_state;
    w_pop      = !w_empty && ready && !dout_enable;
    w_ovf_set  = w_done && w_full && !w_pop;
    w_ferr_set = w_new && r_state == ST_SHIFT;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      dataout     <= '0;
      dout_enable <= 1'b0;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (w_cap) begin
        r_cnt   <= w_done ? '0 : w_cnt_nx;
        r_shift <= w_shift_nx;
      end
      dout_enable <= w_pop;
      if (w_pop) dataout <= w_head;
      // a set event in the same cycle as err_clr wins
      overflow  <= w_ovf_set | (overflow & ~err_clr);
      frame_err <= w_ferr_set | (frame_err & ~err_clr);
    end
  end
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_done),
    .pop   (w_pop),
    .din   (w_shift_nx),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fill)
  );
endmodule

// File: tb/tb_sample_rx.sv
// tb_sample_rx: queue-based reference model with a decoupled scoreboard monitor
module tb_sample_rx;
  localparam int W = 16;
  localparam int D = 4;
  logic clock = 0, reset = 1, bit_en = 0, sdata = 0, fsync = 0, ready = 0, err_clr = 0;
  logic [W-1:0] dataout;
  logic dout_enable, overflow, frame_err;
  logic [$clog2(D):0] fill;
  always #5 clock = ~clock;
  sample_rx #(.DATA_W(W), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .bit_en(bit_en), .sdata(sdata), .fsync(fsync),
    .ready(ready), .err_clr(err_clr), .dataout(dataout), .dout_enable(dout_enable),
    .fill(fill), .overflow(overflow), .frame_err(frame_err)
  );
  int tests = 0, fails = 0;
  logic [W-1:0] mq[$], sb[$], outs[$], exp_outs[$];
  bit bits[$];
  bit m_den = 0, m_ovf = 0, m_ferr = 0;
  logic [W-1:0] m_dout = '0;
  bit rand_mode = 0;
  int gap = 3, rdy_pct = 50;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // reference model: frame assembly from a bit list, FIFO as a queue of words
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete(); bits.delete(); sb.delete();
      m_den = 0; m_ovf = 0; m_ferr = 0; m_dout = '0;
    end else begin
      bit pop, done, fe, of;
      logic [W-1:0] w;
      int n;
      n = mq.size();
      pop = n > 0 && ready && !m_den;
      done = 0; fe = 0; w = '0;
      if (bit_en) begin
        if (fsync) begin
          fe = bits.size() > 0;
          bits.delete();
          bits.push_back(sdata);
        end else if (bits.size() > 0) bits.push_back(sdata);
        if (bits.size() == W) begin
          done = 1;
          foreach (bits[i]) w = {w[W-2:0], bits[i]};
          bits.delete();
        end
      end
      of = done && n >= D && !pop;
      if (pop) begin
        m_dout = mq.pop_front();
        sb.push_back(m_dout);
      end
      m_den = pop;
      if (done && !of) mq.push_back(w);
      m_ovf = of | (m_ovf & !err_clr);
      m_ferr = fe | (m_ferr & !err_clr);
    end
  end
  // monitor: pops the scoreboard whenever the DUT strobes a sample
  always @(posedge clock) begin
    #1;
    if (dout_enable) begin
      outs.push_back(dataout);
      if (sb.size() == 0) check("unexpected_strobe", 1, 0);
      else check("dataout", dataout, sb.pop_front());
    end
    check("dout_enable", dout_enable, m_den);
    check("dataout_hold", dataout, m_dout);
    check("fill", fill, mq.size());
    check("overflow", overflow, m_ovf);
    check("frame_err", frame_err, m_ferr);
  end
  task automatic step();
    @(negedge clock);
    if (rand_mode) begin
      ready = $urandom_range(0, 99) < rdy_pct;
      err_clr = $urandom_range(0, 15) == 0;
    end
  endtask
  task automatic send_bit(input bit d, input bit fs, input bit rdy_last);
    repeat (gap) step();
    bit_en = 1; sdata = d; fsync = fs;
    if (rdy_last) ready = 1;
    step();
    bit_en = 0; fsync = 0;
  endtask
  task automatic send_frame(input logic [W-1:0] w, input int nb, input bit rdy_last);
    for (int i = 0; i < nb; i++) send_bit(w[W-1-i], i == 0, rdy_last && i == nb - 1);
  endtask
  task automatic drain();
    int k;
    k = 0;
    while ((fill != 0 || dout_enable) && k < 200) begin step(); k++; end
    check("drain_timeout", k < 200, 1);
    repeat (3) step();
  endtask
  task automatic check_outs(input string n);
    check({n, "_count"}, outs.size(), exp_outs.size());
    foreach (exp_outs[i]) if (i < outs.size()) check({n, "_word"}, outs[i], exp_outs[i]);
    outs.delete();
    exp_outs.delete();
  endtask
  task automatic pulse_clr();
    err_clr = 1; step(); err_clr = 0; step();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    check("rst_dataout", dataout, 0);
    check("rst_strobe", dout_enable, 0);
    check("rst_fill", fill, 0);
    reset = 0;
    step();
    ready = 1;
    send_frame(16'h8001, W, 0);
    drain();
    exp_outs = {16'h8001};
    check_outs("t1");
    ready = 0;
    send_frame(16'h1234, W, 0);
    send_frame(16'hABCD, W, 0);
    step();
    check("t2_fill", fill, 2);
    check("t2_nostrobe", outs.size(), 0);
    ready = 1;
    drain();
    exp_outs = {16'h1234, 16'hABCD};
    check_outs("t2");
    ready = 0;
    for (int i = 1; i <= 5; i++) send_frame(W'(i), W, 0);
    step();
    check("t3_overflow", overflow, 1);
    check("t3_fill", fill, 4);
    ready = 1;
    drain();
    exp_outs = {16'd1, 16'd2, 16'd3, 16'd4};
    check_outs("t3");
    pulse_clr();
    check("t3_clr", overflow, 0);
    send_frame(16'hAAAA, 7, 0);
    send_frame(16'h00FF, W, 0);
    step();
    check("t4_frame_err", frame_err, 1);
    drain();
    exp_outs = {16'h00FF};
    check_outs("t4");
    send_frame(16'hFFFF, 9, 0);
    reset = 1;
    #1;
    check("t5_rst_dataout", dataout, 0);
    check("t5_rst_strobe", dout_enable, 0);
    check("t5_rst_fill", fill, 0);
    check("t5_rst_ferr", frame_err, 0);
    step();
    reset = 0;
    step();
    send_frame(16'h7FFF, W, 0);
    drain();
    exp_outs = {16'h7FFF};
    check_outs("t5");
    ready = 0;
    for (int i = 1; i <= 4; i++) send_frame(W'(16'h60 + i), W, 0);
    send_frame(16'h65, W, 1);
    check("t6_overflow", overflow, 0);
    check("t6_fill", fill, 4);
    drain();
    exp_outs = {16'h61, 16'h62, 16'h63, 16'h64, 16'h65};
    check_outs("t6");
    rand_mode = 1;
    for (int f = 0; f < 40; f++) begin
      gap = $urandom_range(0, 3);
      rdy_pct = (f < 20) ? 15 : 60;
      send_frame(W'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(1, W - 1) : W, 0);
    end
    rand_mode = 0;
    err_clr = 0;
    ready = 1;
    drain();
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sample_rx.md
Name: sample_rx

Overview:
Serial-to-parallel sample receiver that sits directly upstream of the 128-tap FIR filter. It assembles framed serial audio bits into signed 16-bit samples and buffers them in a small FIFO. Samples are presented to the filter as datain plus a one-cycle din_enable strobe, and only while the filter signals it can accept one, so bursts arriving during the filter's WORK phase are not lost.

Parameters:
DATA_W, 16, sample width in bits; also the number of serial bits per frame.
FIFO_DEPTH, 4, sample buffer depth; must be a power of 2 and at least 2.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high reset.
bit_en  in  1  one-cycle qualifier; sdata and fsync are sampled only when bit_en=1.
sdata  in  1  serial data, MSB first.
fsync  in  1  frame sync; high together with the first (MSB) bit of a frame.
ready  in  1  filter can accept a sample.
err_clr  in  1  clears the sticky error flags.
dataout  out  DATA_W  signed sample to the filter's datain.
dout_enable  out  1  one-cycle strobe to the filter's din_enable.
fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow  out  1  sticky: a completed word was dropped because the FIFO was full.
frame_err  out  1  sticky: fsync arrived mid-frame.

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE; bit count = 0; shift register = 0; FIFO empty.
  - dataout=0, dout_enable=0, fill=0, overflow=0, frame_err=0.
  - Reset mid-frame discards the partial word.
- FSM states: IDLE, SHIFT.
  - IDLE: on bit_en & fsync, capture sdata as the MSB, set count=1, go to SHIFT. bit_en without fsync is ignored.
  - SHIFT, bit_en & !fsync: shift left, inserting sdata at the LSB; count+1.
  - SHIFT, bit capture that brings count to DATA_W: the complete word (including this bit) is pushed at that same edge. Then count=0 and the FSM returns to IDLE.
  - Next frame: its fsync bit can follow immediately, on the next bit_en, which gives back-to-back frames.
  - SHIFT, bit_en & fsync (mid-frame): set frame_err; discard the partial word; treat this bit as a new MSB (count=1, stay in SHIFT).
- Data format: bits are taken as two's complement, MSB first, with no scaling or sign change. dataout is a bit-exact copy of the frame.
- FIFO push: happens on word completion.
  - If full with no pop in the same cycle: drop the word, set overflow, leave the FIFO unchanged.
  - If full and a pop happens in the same cycle: accept the push; overflow is not set.
- Output / pop, evaluated at each rising edge:
  - If FIFO non-empty, ready=1 and dout_enable=0: dataout <= head, dout_enable <= 1, pop.
  - Otherwise: dout_enable <= 0; dataout holds its last value.
  - dout_enable is never high two consecutive cycles, so the maximum rate is one sample per 2 clocks.
- Latency: word completes at edge N → dout_enable high after edge N+1, provided ready=1 and the FIFO was empty.
- Simultaneous push and pop on a non-full FIFO: both take effect; fill is unchanged.
- fill updates at the same edge as push/pop.
- Sticky flags:
  - err_clr=1 clears overflow and frame_err.
  - If a set event and err_clr occur in the same cycle, the set wins.
- FIFO pointers wrap modulo FIFO_DEPTH.
- ready is not required to be stable; it is only sampled at the pop decision.

Decomposition:
- Shared package sample_rx_pkg:
  - state encoding localparams ST_IDLE, ST_SHIFT;
  - DATA_W default;
  - count width, $clog2(DATA_W+1).
- Sub-module sync_fifo(WIDTH, DEPTH):
  - inputs push, pop, din;
  - outputs dout (head, combinational read), full, empty, count;
  - async reset to empty.
- The top level holds the FSM, the shift register, output register and sticky flags.

Test Plan:
1. Reset, then frame 16'h8001 with fsync on the MSB, bit_en every 4 clocks, ready=1 → exactly one dout_enable pulse, one clock after the last-bit edge; dataout=16'h8001 (-32767); fill returns to 0.
2. Back-to-back frames 16'h1234, 16'hABCD with ready=0 → fill=2, no strobes. Then ready=1 → strobes with dataout 16'h1234, then 16'hABCD, 2 clocks apart; fill=0.
3. Five frames 1..5 with ready=0, FIFO_DEPTH=4 → overflow=1, fill=4. Then ready=1 → outputs 1, 2, 3, 4 only. err_clr pulse → overflow=0.
4. fsync reasserted on the 8th bit of a frame, followed by a clean 16-bit frame 16'h00FF → frame_err=1; single output 16'h00FF; no output from the partial word.
5. Reset asserted for 1 clock after 9 bits of a frame, then frame 16'h7FFF → all outputs 0 during reset; exactly one output, 16'h7FFF.
6. FIFO full (4 words), ready rises so the pop lands on the same edge as a 5th word's completion → overflow stays 0; fill stays 4; output order is preserved.
